// File: rtl/symbol_gen.sv
// symbol_gen: shows NUM_SYMBOLS LFSR-picked symbols on a 7-seg digit per round, counting magic (idx 0) symbols.
// Optional SYM_NO_REPEAT_EN: bumps idx by one when it would repeat the previous symbol.
module symbol_gen #(
  parameter int          NUM_SYMBOLS = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        Clk100M,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] symGenMax,
  output logic [7:0]  symSeg,
  output logic        symValid,
  output logic [7:0]  magicSymbolCount,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_DONE} state_t;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  state_t      r_state, w_next;
  logic [15:0] r_lfsr, w_lfsr_nxt;
  logic [2:0]  r_idx, w_idx;
  logic [31:0] r_m, r_ph, w_g;
  logic [7:0]  r_cnt, r_sym, w_cnt_base, w_sym_base;
  logic        w_enter, w_show_end, w_gap_end, w_last;
`ifdef SYM_NO_REPEAT_EN
  logic [2:0]  w_prev;
`endif

  function automatic logic [7:0] seg_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    seg_lut = 8'h9C;
      3'd1:    seg_lut = 8'hF7;
      3'd2:    seg_lut = 8'hBF;
      3'd3:    seg_lut = 8'hFE;
      3'd4:    seg_lut = 8'hF9;
      3'd5:    seg_lut = 8'hCF;
      3'd6:    seg_lut = 8'hB6;
      default: seg_lut = 8'hC0;
    endcase
  endfunction

  always_comb begin
    w_g        = r_m >> 1;
    w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
`ifdef SYM_NO_REPEAT_EN
    // r_idx still holds the previous symbol; a fresh round compares against 7
    w_prev = (r_state == S_IDLE) ? 3'd7 : r_idx;
    w_idx  = (w_lfsr_nxt[2:0] == w_prev) ? w_lfsr_nxt[2:0] + 3'd1 : w_lfsr_nxt[2:0];
`else
    w_idx  = w_lfsr_nxt[2:0];
`endif
    w_show_end = (r_ph == r_m - 32'd1);
    w_gap_end  = (r_ph == w_g - 32'd1);
    w_last     = (r_sym == 8'(NUM_SYMBOLS));
    w_cnt_base = (r_state == S_IDLE) ? 8'd0 : r_cnt;
    w_sym_base = (r_state == S_IDLE) ? 8'd0 : r_sym;

    w_next  = r_state;
    w_enter = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next  = S_SHOW;
          w_enter = 1'b1;
        end
      end
      S_SHOW: begin
        if (w_show_end) begin
          if (w_g != 32'd0) begin
            w_next = S_GAP;
          end else if (w_last) begin
            w_next = S_DONE;
          end else begin
            w_enter = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_gap_end) begin
          if (w_last) begin
            w_next = S_DONE;
          end else begin
            w_next  = S_SHOW;
            w_enter = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase

    symSeg           = (r_state == S_SHOW) ? seg_lut(r_idx) : 8'hFF;
    symValid         = (r_state == S_SHOW) && (r_ph == 32'd0);
    busy             = (r_state == S_SHOW) || (r_state == S_GAP);
    done             = (r_state == S_DONE);
    magicSymbolCount = r_cnt;
  end

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED_EFF;
      r_idx   <= 3'd0;
      r_m     <= 32'd1;
      r_ph    <= 32'd0;
      r_cnt   <= 8'd0;
      r_sym   <= 8'd0;
    end else begin
      r_state <= w_next;
      // phase counter restarts on every SHOW entry, including SHOW->SHOW when there is no gap
      if (w_enter || (w_next != r_state) || (r_state == S_IDLE))
        r_ph <= 32'd0;
      else
        r_ph <= r_ph + 32'd1;
      if (r_state == S_IDLE && start)
        r_m <= (symGenMax == 32'd0) ? 32'd1 : symGenMax;
      if (w_enter) begin
        r_lfsr <= w_lfsr_nxt;
        r_idx  <= w_idx;
        r_sym  <= w_sym_base + 8'd1;
        r_cnt  <= w_cnt_base + {7'd0, (w_idx == 3'd0) && (w_cnt_base != 8'hFF)};
      end
    end
  end

endmodule

// File: tb/tb_symbol_gen.sv
// Randomized rounds against a cycle-indexed reference of the round schedule and LFSR symbol sequence.
module tb_symbol_gen;
  localparam int          N    = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] sgm;
  logic [7:0]  seg, cnt;
  logic        vld, busy, done;

  symbol_gen #(.NUM_SYMBOLS(N), .SEED(SEED)) dut (
    .Clk100M(clk), .reset(reset), .start(start), .symGenMax(sgm),
    .symSeg(seg), .symValid(vld), .magicSymbolCount(cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  lut [0:7] = '{8'h9C, 8'hF7, 8'hBF, 8'hFE, 8'hF9, 8'hCF, 8'hB6, 8'hC0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // One round: start in cycle 0, cycles 1..done checked against the schedule, then the idle cycle after.
  task automatic run_round(input logic [31:0] gm, input int abuse_cyc, input bit start_in_done);
    int m, g, p, dc, ecnt, n_vld;
    int idx [N];
    int e_seg, e_vld, e_busy, e_done, e_rep;
    logic [7:0] last_seg;
    int ph, k;
    bit show;
`ifdef SYM_NO_REPEAT_EN
    int prev;
    prev = 7;
`endif
    m  = (gm == 0) ? 1 : int'(gm);
    g  = m / 2;
    p  = m + g;
    dc = 1 + N * p;
    ecnt = 0;
    for (int i = 0; i < N; i++) begin
      m_lfsr = lstep(m_lfsr);
      idx[i] = int'(m_lfsr[2:0]);
`ifdef SYM_NO_REPEAT_EN
      if (idx[i] == prev) idx[i] = (idx[i] + 1) % 8;
      prev = idx[i];
`endif
      if (idx[i] == 0 && ecnt < 255) ecnt++;
    end
    e_seg = 0; e_vld = 0; e_busy = 0; e_done = 0; e_rep = 0; n_vld = 0; last_seg = 8'hFF;
    sgm = gm;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= dc; c++) begin
      ph = (c - 1) % p;
      k  = (c - 1) / p;
      if (c < dc) begin
        show = (ph < m);
        if (seg !== (show ? lut[idx[k]] : 8'hFF)) e_seg++;
        if (vld !== (ph == 0)) e_vld++;
        if (busy !== 1'b1) e_busy++;
        if (done !== 1'b0) e_done++;
      end else begin
        if (seg !== 8'hFF) e_seg++;
        if (vld !== 1'b0) e_vld++;
        if (busy !== 1'b0) e_busy++;
        if (done !== 1'b1) e_done++;
      end
      if (vld === 1'b1) begin
        if (n_vld > 0 && seg === last_seg) e_rep++;
        last_seg = seg;
        n_vld++;
      end
      if (c == 5) sgm = $urandom;
      start = (c == abuse_cyc && c < dc) || (start_in_done && c == dc);
      if (c < dc) tick();
    end
    tick();
    start = 1'b0;
    chk("seg_sched_errs", e_seg, 0);
    chk("valid_sched_errs", e_vld, 0);
    chk("busy_sched_errs", e_busy, 0);
    chk("done_sched_errs", e_done, 0);
    chk("valid_pulses", n_vld, N);
    chk("count_at_end", cnt, ecnt);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
`ifdef SYM_NO_REPEAT_EN
    chk("no_repeat_errs", e_rep, 0);
`endif
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
    chk("count_hold", cnt, ecnt);
  endtask

  initial begin
    int nd;
    reset = 1'b1; start = 1'b0; sgm = 32'd4;
    m_lfsr = SEED;
    tick();
    start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_seg", seg, 8'hFF);
    chk("rst_count", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", vld, 0);
    tick();
    chk("rst_start_same_cycle_busy", busy, 0);

    run_round(32'd4, 0, 1'b0);
    run_round(32'd3, 0, 1'b0);
    run_round(32'd0, 0, 1'b0);
    run_round(32'd1, 0, 1'b1);
    run_round(32'd4, 10, 1'b1);

    // abort with reset in cycle 20
    sgm = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_lfsr = SEED;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", cnt, 0);
    chk("abort_seg", seg, 8'hFF);
    chk("abort_valid", vld, 0);
    nd = 0;
    for (int c = 0; c < 110; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) nd++;
      tick();
    end
    chk("abort_quiet_errs", nd, 0);

    for (int r = 0; r < 20; r++)
      run_round(32'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0,
                1'($urandom_range(0, 1)));
    for (int r = 0; r < 200; r++)
      run_round(32'd2, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
